ultrasonic_ping_ctrl: RTL

Upstream sequencer for the ultrasonic range finder. It issues the trigger pulse to the sensor and runs the 13-bit `timer` that the echo-capture stage samples. It also produces the clear pulse that re-arms that capture stage before each ping. It tracks the echo pulse to report completion or timeout, then enforces a hold-off before the next ping.

---
 rtl/ultrasonic_ping_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ultrasonic_ping_ctrl.sv
// Ping sequencer for the ultrasonic range finder: trigger pulse, echo tracking, timer and hold-off.
// Define PING_AUTO_EN to add the `auto` input for continuous back-to-back pings.
module ultrasonic_ping_ctrl #(
    parameter int TRIG_CYCLES    = 500,
    parameter int TICK_DIV       = 50,
    parameter int HOLDOFF_CYCLES = 3000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
`ifdef PING_AUTO_EN
    input  logic        auto,
`endif
    input  logic        echo,
    output logic        trig,
    output logic [12:0] timer,
    output logic        capture_clear,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    localparam int CNT_MAX = (TRIG_CYCLES > HOLDOFF_CYCLES) ? TRIG_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [12:0]      TIMER_TOP = 13'h1FFF;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIG    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [PRE_W-1:0] pre_reg, pre_next;
    logic [12:0]      timer_reg, timer_next;
    logic             clear_reg, clear_next;
    logic             done_reg, done_next;
    logic             timeout_reg, timeout_next;
    logic [1:0]       echo_sync_reg;
    logic             echo_s;
    logic             launch;
    logic             tick;

`ifdef PING_AUTO_EN
    assign launch = start | auto;
`else
    assign launch = start;
`endif

    assign echo_s = echo_sync_reg[1];
    assign tick   = (pre_reg == PRE_LAST);

    // Raw echo is asynchronous to clk; two flops before any decision uses it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            echo_sync_reg <= 2'b00;
        end else begin
            echo_sync_reg <= {echo_sync_reg[0], echo};
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pre_next     = pre_reg;
        timer_next   = timer_reg;
        clear_next   = 1'b0;
        done_next    = 1'b0;
        timeout_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                timer_next = 13'd0;
                if (launch) begin
                    state_next = S_TRIG;
                    cnt_next   = '0;
                    clear_next = 1'b1;
                end
            end
            S_TRIG: begin
                if (cnt_reg == TRIG_LAST) begin
                    state_next = S_WAIT;
                    timer_next = 13'd0;
                    pre_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_WAIT, S_MEASURE: begin
                if (state_reg == S_MEASURE && !echo_s) begin
                    // Echo ended: freeze the timer at its current value.
                    state_next = S_HOLDOFF;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    if (state_reg == S_WAIT && echo_s) begin
                        state_next = S_MEASURE;
                    end
                    if (tick) begin
                        pre_next = '0;
                        if (timer_reg != TIMER_TOP) begin
                            timer_next = timer_reg + 13'd1;
                        end
                        if (timer_reg == TIMER_TOP - 13'd1) begin
                            state_next   = S_HOLDOFF;
                            cnt_next     = '0;
                            timeout_next = 1'b1;
                        end
                    end else begin
                        pre_next = pre_reg + 1'b1;
                    end
                end
            end
            S_HOLDOFF: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = S_IDLE;
                    timer_next = 13'd0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                timer_next = 13'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            pre_reg     <= '0;
            timer_reg   <= 13'd0;
            clear_reg   <= 1'b0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pre_reg     <= pre_next;
            timer_reg   <= timer_next;
            clear_reg   <= clear_next;
            done_reg    <= done_next;
            timeout_reg <= timeout_next;
        end
    end

    assign trig          = (state_reg == S_TRIG);
    assign busy          = (state_reg != S_IDLE);
    assign timer         = timer_reg;
    assign capture_clear = clear_reg;
    assign done          = done_reg;
    assign timeout       = timeout_reg;

endmodule
